mult_pipeline: RTL and testbench

Five-stage pipelined integer multiplier that produces the `mult5_*` result bundle consumed by the mult5-to-write-back latch. It accepts one MUL-class instruction per cycle from decode and tracks destination registers in flight for hazard detection. Stages m1..m5 are registers; m5 drives the outputs directly. Write-back captures the outputs one edge later.

---
 rtl/mult_pkg.sv | 24 ++
 rtl/mult_pp17.sv | 20 ++
 rtl/mult_pipeline.sv | 125 ++++++++++++
 tb/tb_mult_pipeline.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: funct3 codes, pipeline depth and per-stage control bundle for mult_pipeline
package mult_pkg;

    localparam int         MULT_NUM_STAGES = 5;

    localparam logic [2:0] MULT_OP_MUL     = 3'b000;
    localparam logic [2:0] MULT_OP_MULH    = 3'b001;
    localparam logic [2:0] MULT_OP_MULHSU  = 3'b010;
    localparam logic [2:0] MULT_OP_MULHU   = 3'b011;

    typedef struct packed {
        logic        valid;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] instruction;
        logic [31:0] pc;
    } mult_stage_t;

    // Extend a 32-bit operand to 33 bits, sign-extending when sgn is set
    function automatic logic [32:0] mult_ext(input logic [31:0] v, input logic sgn);
        return {sgn & v[31], v};
    endfunction

endpackage

// File: rtl/mult_pp17.sv
// mult_pp17: registered 17x17 signed multiplier used for the m2 partial products
module mult_pp17 (
    input  logic               clk_i,
    input  logic               rsn_i,
    input  logic signed [16:0] a_i,
    input  logic signed [16:0] b_i,
    output logic signed [33:0] p_o
);

    logic signed [33:0] p_q;

    // Capture the full-width signed product
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) p_q <= '0;
        else        p_q <= a_i * b_i;
    end

    assign p_o = p_q;

endmodule

// File: rtl/mult_pipeline.sv
// mult_pipeline: five-stage pipelined RISC-V multiplier feeding the mult5 write-back latch.
// Define MULT_MULH_EN to support MULH/MULHSU/MULHU; otherwise only MUL writes back.
module mult_pipeline
    import mult_pkg::*;
#(
    parameter int NUM_STAGES = MULT_NUM_STAGES
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        dec_mult_valid_i,
    input  logic [2:0]  dec_mult_op_i,
    input  logic [31:0] dec_src1_i,
    input  logic [31:0] dec_src2_i,
    input  logic [4:0]  dec_write_addr_i,
    input  logic [31:0] dec_instruction_i,
    input  logic [31:0] dec_pc_i,
    input  logic        flush_i,
    output logic [31:0] mult5_int_write_data_o,
    output logic [4:0]  mult5_write_addr_o,
    output logic        mult5_int_write_enable_o,
    output logic [31:0] mult5_instruction_o,
    output logic [31:0] mult5_pc_o,
    output logic [31:0] mult_pending_mask_o
);

`ifdef MULT_MULH_EN
    localparam int SUM_W = 66;
    localparam int NT    = 4;
`else
    localparam int SUM_W = 32;
    localparam int NT    = 3;
`endif
    localparam int L = NUM_STAGES - 1;

    mult_stage_t [NUM_STAGES-1:0] st_q, st_d;
    logic [32:0]              a_q, a_d, b_q, b_d;
    logic signed [33:0]       pp [NT];
    logic [NT-1:0][SUM_W-1:0] t_q, t_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [31:0]              data_q, data_d;
    logic                     op_ok;
    logic                     unused_top;

    // Shift the control bundles; divide ops never become valid and flush kills everything not yet in m5
    always_comb begin
        st_d[0] = '{valid: dec_mult_valid_i & ~dec_mult_op_i[2] & ~flush_i, op: dec_mult_op_i,
                    rd: dec_write_addr_i, instruction: dec_instruction_i, pc: dec_pc_i};
        for (int i = 1; i < NUM_STAGES; i++) begin
            st_d[i]       = st_q[i-1];
            st_d[i].valid = st_q[i-1].valid & ~flush_i;
        end
    end

    // m1 operand extension: rs1 is signed for MULH/MULHSU, rs2 only for MULH
    assign a_d = mult_ext(dec_src1_i, dec_mult_op_i == MULT_OP_MULH || dec_mult_op_i == MULT_OP_MULHSU);
    assign b_d = mult_ext(dec_src2_i, dec_mult_op_i == MULT_OP_MULH);

    // m2: split each 33-bit operand into an unsigned low half and a signed high half
    mult_pp17 u_pp_ll (.clk_i(clk_i), .rsn_i(rsn_i), .a_i({1'b0, a_q[15:0]}), .b_i({1'b0, b_q[15:0]}), .p_o(pp[0]));
    mult_pp17 u_pp_lh (.clk_i(clk_i), .rsn_i(rsn_i), .a_i({1'b0, a_q[15:0]}), .b_i(b_q[32:16]),        .p_o(pp[1]));
    mult_pp17 u_pp_hl (.clk_i(clk_i), .rsn_i(rsn_i), .a_i(a_q[32:16]),        .b_i({1'b0, b_q[15:0]}), .p_o(pp[2]));

`ifdef MULT_MULH_EN
    mult_pp17 u_pp_hh (.clk_i(clk_i), .rsn_i(rsn_i), .a_i(a_q[32:16]),        .b_i(b_q[32:16]),        .p_o(pp[3]));

    // m3 alignment of the four partial products into 66-bit signed terms
    assign t_d[0] = {{32{pp[0][33]}}, pp[0]};
    assign t_d[1] = {{16{pp[1][33]}}, pp[1], 16'b0};
    assign t_d[2] = {{16{pp[2][33]}}, pp[2], 16'b0};
    assign t_d[3] = {pp[3], 32'b0};

    assign data_d     = st_q[L-1].op == MULT_OP_MUL ? sum_q[31:0] : sum_q[63:32];
    assign op_ok      = 1'b1;
    assign unused_top = ^sum_q[65:64];
`else
    // Only the low word is needed, so the cross terms contribute just their low 16 bits
    assign t_d[0] = pp[0][31:0];
    assign t_d[1] = {pp[1][15:0], 16'b0};
    assign t_d[2] = {pp[2][15:0], 16'b0};

    assign data_d     = st_q[L-1].op == MULT_OP_MUL ? sum_q : '0;
    assign op_ok      = st_q[L].op == MULT_OP_MUL;
    assign unused_top = ^{pp[0][33:32], pp[1][33:16], pp[2][33:16]};
`endif

    // m4 adder over all aligned terms
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NT; i++) sum_d = sum_d + t_q[i];
    end

    // Stage registers for control and datapath; reset discards all in-flight ops at once
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            st_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            t_q    <= '0;
            sum_q  <= '0;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            a_q    <= a_d;
            b_q    <= b_d;
            t_q    <= t_d;
            sum_q  <= sum_d;
            data_q <= data_d;
        end
    end

    assign mult5_int_write_data_o   = data_q;
    assign mult5_write_addr_o       = st_q[L].rd;
    assign mult5_int_write_enable_o = st_q[L].valid & (|st_q[L].rd) & op_ok;
    assign mult5_instruction_o      = st_q[L].instruction;
    assign mult5_pc_o               = st_q[L].pc;

    // Hazard mask: any valid stage marks its rd; x0 is never pending
    always_comb begin
        mult_pending_mask_o = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (st_q[i].valid) mult_pending_mask_o[st_q[i].rd] = 1'b1;
        mult_pending_mask_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_mult_pipeline.sv
// tb_mult_pipeline: randomized scoreboard bench for mult_pipeline (honours MULT_MULH_EN)
module tb_mult_pipeline;

`ifdef MULT_MULH_EN
    localparam bit MULH_EN = 1'b1;
`else
    localparam bit MULH_EN = 1'b0;
`endif

    typedef struct {
        int          k;
        bit          live;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic        dec_mult_valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  dec_mult_op_i = '0;
    logic [31:0] dec_src1_i = '0;
    logic [31:0] dec_src2_i = '0;
    logic [4:0]  dec_write_addr_i = '0;
    logic [31:0] dec_instruction_i = '0;
    logic [31:0] dec_pc_i = '0;
    logic [31:0] wdata, instr, pc, mask, exp_mask;
    logic [4:0]  waddr;
    logic        we, exp_we;
    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    mult_pipeline dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .dec_mult_valid_i(dec_mult_valid_i), .dec_mult_op_i(dec_mult_op_i),
        .dec_src1_i(dec_src1_i), .dec_src2_i(dec_src2_i),
        .dec_write_addr_i(dec_write_addr_i), .dec_instruction_i(dec_instruction_i),
        .dec_pc_i(dec_pc_i), .flush_i(flush_i),
        .mult5_int_write_data_o(wdata), .mult5_write_addr_o(waddr),
        .mult5_int_write_enable_o(we), .mult5_instruction_o(instr),
        .mult5_pc_o(pc), .mult_pending_mask_o(mask)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    // Architectural result of a RISC-V multiply, straight from 64-bit arithmetic
    function automatic logic [31:0] ref_mult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        if (op == 3'd1)      p = sa * sb;
        else if (op == 3'd2) p = sa * ub;
        else                 p = {32'b0, a} * {32'b0, b};
        return op == 3'd0 ? p[31:0] : p[63:32];
    endfunction

    // Model: each accepted issue is due at the output four edges after it is sampled
    initial forever begin
        @(posedge clk_i);
        if (rsn_i) begin
            cyc++;
            if (flush_i) foreach (q[i]) q[i].live = 1'b0;
            if (dec_mult_valid_i && !flush_i && !dec_mult_op_i[2])
                q.push_back('{cyc, 1'b1, dec_mult_op_i, dec_write_addr_i,
                              ref_mult(dec_mult_op_i, dec_src1_i, dec_src2_i),
                              dec_instruction_i, dec_pc_i});
        end
    end

    // Monitor: compare mask every cycle and pop the op due at m5
    initial forever begin
        @(negedge clk_i);
        if (!rsn_i) begin
            chk("rst_we", 32'(we), 32'd0);
            chk("rst_data", wdata, 32'd0);
            chk("rst_mask", mask, 32'd0);
        end else begin
            exp_mask = '0;
            foreach (q[i]) if (q[i].live && q[i].rd != 5'd0) exp_mask[q[i].rd] = 1'b1;
            chk("mask", mask, exp_mask);
            if (q.size() > 0 && q[0].k + 4 == cyc) begin
                e = q.pop_front();
                exp_we = e.live && e.rd != 5'd0 && (MULH_EN || e.op == 3'd0);
                chk("we", 32'(we), 32'(exp_we));
                if (exp_we) begin
                    chk("data", wdata, e.data);
                    chk("addr", 32'(waddr), 32'(e.rd));
                    chk("instr", instr, e.instr);
                    chk("pc", pc, e.pc);
                end
            end else chk("idle_we", 32'(we), 32'd0);
        end
    end

    task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit fl);
        @(negedge clk_i);
        dec_mult_valid_i  = v;
        dec_mult_op_i     = op;
        dec_src1_i        = a;
        dec_src2_i        = b;
        dec_write_addr_i  = rd;
        flush_i           = fl;
        dec_instruction_i = $urandom;
        dec_pc_i          = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        int s;
        s = $urandom_range(0, 3);
        return s == 0 ? 32'h8000_0000 : s == 1 ? 32'hFFFF_FFFF : 32'($urandom);
    endfunction

    task automatic rnd(input int n);
        repeat (n) drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(),
                         5'($urandom), $urandom_range(0, 15) == 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rsn_i = 1'b1;
        drive(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
        idle(7);
        drive(1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
        drive(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
        drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
        drive(1'b1, 3'd0, 32'h0001_0000, 32'h0001_0000, 5'd4, 1'b0);
        idle(6);
        drive(1'b1, 3'd0, 32'd3, 32'd4, 5'd0, 1'b0);
        idle(6);
        for (int i = 0; i < 5; i++) drive(1'b1, 3'd0, $urandom, $urandom, 5'(10 + i), 1'b0);
        drive(1'b1, 3'd0, 32'd9, 32'd9, 5'd15, 1'b1);
        idle(6);
        drive(1'b1, 3'b100, 32'd5, 32'd6, 5'd7, 1'b0);
        idle(6);
        drive(1'b1, 3'd1, 32'd5, 32'd6, 5'd9, 1'b0);
        idle(7);
        rnd(200);
        @(posedge clk_i);
        #2 rsn_i = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_data", wdata, 32'd0);
        chk("arst_addr", 32'(waddr), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_mask", mask, 32'd0);
        q.delete();
        idle(2);
        rsn_i = 1'b1;
        idle(3);
        rnd(200);
        idle(8);
        chk("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
